// File: rtl/mem_arbiter_pkg.sv
// Shared encodings, address map and request bundle for the memory0 arbiter.
package cpu0_mem_pkg;

    localparam logic [1:0] BYTE  = 2'b00;
    localparam logic [1:0] INT16 = 2'b01;
    localparam logic [1:0] INT24 = 2'b10;
    localparam logic [1:0] INT32 = 2'b11;

    localparam logic [31:0] MEMSIZE = 32'h0008_0000;
    localparam logic [31:0] IOADDR  = 32'h0008_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef struct packed {
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Writes to the console address are the only out-of-range access let through.
    function automatic logic addr_err(input mem_req_t r);
        return (r.addr > (MEMSIZE - 32'd4)) && (r.rw || (r.addr != IOADDR));
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory0 bus between two requesters with round-robin grant,
// a fixed-length access window and a registered read-data/ack return.
module mem_arbiter
    import cpu0_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        r0_req,
    input  logic        r0_rw,
    input  logic [1:0]  r0_size,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_ack,
    output logic        r0_err,
    input  logic        r1_req,
    input  logic        r1_rw,
    input  logic [1:0]  r1_size,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_ack,
    output logic        r1_err,
    output logic [31:0] rdata,
    output logic [1:0]  gnt,
    output logic        m_en,
    output logic        m_rw,
    output logic [1:0]  m_size,
    output logic [31:0] m_abus,
    output logic [31:0] m_dout,
    input  logic [31:0] m_din
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    state_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           last_q, last_d;
    logic           m_en_q, m_en_d;
    logic           m_rw_q, m_rw_d;
    logic [1:0]     m_size_q, m_size_d;
    logic [31:0]    m_abus_q, m_abus_d;
    logic [31:0]    m_dout_q, m_dout_d;
    logic           r0_ack_q, r0_ack_d;
    logic           r0_err_q, r0_err_d;
    logic           r1_ack_q, r1_ack_d;
    logic           r1_err_q, r1_err_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [1:0]     gnt_q, gnt_d;

    logic [1:0]     pick;
    mem_req_t       sel;

    rr_arb2 u_rr_arb2 (
        .req  ({r1_req, r0_req}),
        .last (last_q),
        .pick (pick)
    );

    always_comb begin
        sel = pick[1] ? '{rw: r1_rw, size: r1_size, addr: r1_addr, wdata: r1_wdata}
                      : '{rw: r0_rw, size: r0_size, addr: r0_addr, wdata: r0_wdata};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        m_en_d   = m_en_q;
        m_rw_d   = m_rw_q;
        m_size_d = m_size_q;
        m_abus_d = m_abus_q;
        m_dout_d = m_dout_q;
        r0_ack_d = r0_ack_q;
        r0_err_d = r0_err_q;
        r1_ack_d = r1_ack_q;
        r1_err_d = r1_err_q;
        rdata_d  = rdata_q;
        gnt_d    = gnt_q;

        case (state_q)
            IDLE: begin
                if (pick != 2'b00) begin
                    m_rw_d   = sel.rw;
                    m_size_d = sel.size;
                    m_abus_d = sel.addr;
                    m_dout_d = sel.wdata;
                    gnt_d    = pick;
                    last_d   = pick[1];
                    cnt_d    = CNT_INIT;
                    if (addr_err(sel)) begin
                        // Rejected accesses never touch the bus; ack straight from DONE.
                        m_en_d   = 1'b0;
                        rdata_d  = '0;
                        r0_ack_d = pick[0];
                        r0_err_d = pick[0];
                        r1_ack_d = pick[1];
                        r1_err_d = pick[1];
                        state_d  = DONE;
                    end else begin
                        m_en_d  = 1'b1;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (m_rw_q) begin
                        rdata_d = m_din;
                    end
                    m_en_d   = 1'b0;
                    r0_ack_d = ~last_q;
                    r1_ack_d = last_q;
                    r0_err_d = 1'b0;
                    r1_err_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                r0_ack_d = 1'b0;
                r0_err_d = 1'b0;
                r1_ack_d = 1'b0;
                r1_err_d = 1'b0;
                gnt_d    = 2'b00;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            m_en_q   <= 1'b0;
            m_rw_q   <= 1'b1;
            m_size_q <= INT32;
            m_abus_q <= '0;
            m_dout_q <= '0;
            r0_ack_q <= 1'b0;
            r0_err_q <= 1'b0;
            r1_ack_q <= 1'b0;
            r1_err_q <= 1'b0;
            rdata_q  <= '0;
            gnt_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            m_en_q   <= m_en_d;
            m_rw_q   <= m_rw_d;
            m_size_q <= m_size_d;
            m_abus_q <= m_abus_d;
            m_dout_q <= m_dout_d;
            r0_ack_q <= r0_ack_d;
            r0_err_q <= r0_err_d;
            r1_ack_q <= r1_ack_d;
            r1_err_q <= r1_err_d;
            rdata_q  <= rdata_d;
            gnt_q    <= gnt_d;
        end
    end

    assign r0_ack = r0_ack_q;
    assign r0_err = r0_err_q;
    assign r1_ack = r1_ack_q;
    assign r1_err = r1_err_q;
    assign rdata  = rdata_q;
    assign gnt    = gnt_q;
    assign m_en   = m_en_q;
    assign m_rw   = m_rw_q;
    assign m_size = m_size_q;
    assign m_abus = m_abus_q;
    assign m_dout = m_dout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: instance a (WAIT_CYCLES=1) on a big-endian byte memory,
// instance b (WAIT_CYCLES=3) on a constant-data memory.
module tb_mem_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic        a_reset, a_r0_req, a_r0_rw, a_r1_req, a_r1_rw;
    logic [1:0]  a_r0_size, a_r1_size;
    logic [31:0] a_r0_addr, a_r0_wdata, a_r1_addr, a_r1_wdata;
    logic        a_r0_ack, a_r0_err, a_r1_ack, a_r1_err;
    logic [31:0] a_rdata, a_m_abus, a_m_dout, a_m_din;
    logic [1:0]  a_gnt, a_m_size;
    logic        a_m_en, a_m_rw;

    logic        b_reset, b_r0_req, b_r0_rw, b_r1_req, b_r1_rw;
    logic [1:0]  b_r0_size, b_r1_size;
    logic [31:0] b_r0_addr, b_r0_wdata, b_r1_addr, b_r1_wdata;
    logic        b_r0_ack, b_r0_err, b_r1_ack, b_r1_err;
    logic [31:0] b_rdata, b_m_abus, b_m_dout, b_m_din;
    logic [1:0]  b_gnt, b_m_size;
    logic        b_m_en, b_m_rw;

    mem_arbiter #(.WAIT_CYCLES(1)) dut_a (
        .clock(clock), .reset(a_reset),
        .r0_req(a_r0_req), .r0_rw(a_r0_rw), .r0_size(a_r0_size), .r0_addr(a_r0_addr),
        .r0_wdata(a_r0_wdata), .r0_ack(a_r0_ack), .r0_err(a_r0_err),
        .r1_req(a_r1_req), .r1_rw(a_r1_rw), .r1_size(a_r1_size), .r1_addr(a_r1_addr),
        .r1_wdata(a_r1_wdata), .r1_ack(a_r1_ack), .r1_err(a_r1_err),
        .rdata(a_rdata), .gnt(a_gnt), .m_en(a_m_en), .m_rw(a_m_rw), .m_size(a_m_size),
        .m_abus(a_m_abus), .m_dout(a_m_dout), .m_din(a_m_din)
    );

    mem_arbiter #(.WAIT_CYCLES(3)) dut_b (
        .clock(clock), .reset(b_reset),
        .r0_req(b_r0_req), .r0_rw(b_r0_rw), .r0_size(b_r0_size), .r0_addr(b_r0_addr),
        .r0_wdata(b_r0_wdata), .r0_ack(b_r0_ack), .r0_err(b_r0_err),
        .r1_req(b_r1_req), .r1_rw(b_r1_rw), .r1_size(b_r1_size), .r1_addr(b_r1_addr),
        .r1_wdata(b_r1_wdata), .r1_ack(b_r1_ack), .r1_err(b_r1_err),
        .rdata(b_rdata), .gnt(b_gnt), .m_en(b_m_en), .m_rw(b_m_rw), .m_size(b_m_size),
        .m_abus(b_m_abus), .m_dout(b_m_dout), .m_din(b_m_din)
    );

    // memory0 model: big-endian, low-order bytes of the data word, 256 bytes visible.
    logic [7:0] mem [0:255];
    logic       mem_init;

    always_comb begin
        a_m_din = '0;
        if (a_m_en && a_m_rw) begin
            for (int i = 0; i <= int'(a_m_size); i++) begin
                logic [31:0] ai;
                ai = a_m_abus + 32'(i);
                a_m_din = {a_m_din[23:0], mem[ai[7:0]]};
            end
        end
    end

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[0]  <= 8'hDE; mem[1]  <= 8'hAD; mem[2]  <= 8'hBE; mem[3]  <= 8'hEF;
            mem[16] <= 8'h01; mem[17] <= 8'h02; mem[18] <= 8'h03; mem[19] <= 8'h04;
        end else if (a_m_en && !a_m_rw && a_m_abus < 32'd256) begin
            for (int i = 0; i <= int'(a_m_size); i++) begin
                logic [31:0] ai;
                ai = a_m_abus + 32'(i);
                mem[ai[7:0]] <= a_m_dout[8*(int'(a_m_size) - i) +: 8];
            end
        end
    end

    assign b_m_din = (b_m_en && b_m_rw) ? 32'hCAFE_F00D : 32'h0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit which_b, input bit port, input logic req, input logic rw,
                         input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        if (!which_b && !port) begin
            a_r0_req = req; a_r0_rw = rw; a_r0_size = size; a_r0_addr = addr; a_r0_wdata = wdata;
        end else if (!which_b) begin
            a_r1_req = req; a_r1_rw = rw; a_r1_size = size; a_r1_addr = addr; a_r1_wdata = wdata;
        end else if (!port) begin
            b_r0_req = req; b_r0_rw = rw; b_r0_size = size; b_r0_addr = addr; b_r0_wdata = wdata;
        end else begin
            b_r1_req = req; b_r1_rw = rw; b_r1_size = size; b_r1_addr = addr; b_r1_wdata = wdata;
        end
    endtask

    // Runs one transaction to its ack (bounded) and reports what was observed.
    task automatic issue(input bit which_b, input bit port, input logic rw, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output bit seen, output logic err, output logic [31:0] rd, output int lat,
                         output int en_cycles, output logic [31:0] abus_seen, output logic [1:0] gnt_seen);
        logic ack, en;
        seen = 0; err = 1'bx; rd = 'x; lat = 0; en_cycles = 0; abus_seen = '0; gnt_seen = 2'b00;
        drive(which_b, port, 1'b1, rw, size, addr, wdata);
        for (int i = 1; i <= 20; i++) begin
            tick();
            en  = which_b ? b_m_en : a_m_en;
            ack = which_b ? (port ? b_r1_ack : b_r0_ack) : (port ? a_r1_ack : a_r0_ack);
            if (en) begin
                en_cycles++;
                abus_seen = which_b ? b_m_abus : a_m_abus;
            end
            if (ack) begin
                seen     = 1;
                lat      = i;
                err      = which_b ? (port ? b_r1_err : b_r0_err) : (port ? a_r1_err : a_r0_err);
                rd       = which_b ? b_rdata : a_rdata;
                gnt_seen = which_b ? b_gnt : a_gnt;
                break;
            end
        end
        drive(which_b, port, 1'b0, 1'b1, 2'b11, 32'h0, 32'h0);
        if (seen) tick();
    endtask

    task automatic test_reset();
        a_reset = 1'b1; b_reset = 1'b1; mem_init = 1'b1;
        drive(0, 0, 0, 1, 2'b11, 0, 0); drive(0, 1, 0, 1, 2'b11, 0, 0);
        drive(1, 0, 0, 1, 2'b11, 0, 0); drive(1, 1, 0, 1, 2'b11, 0, 0);
        tick(); tick();
        a_reset = 1'b0; b_reset = 1'b0; mem_init = 1'b0;
        checks++;
        if ({a_m_en, a_m_rw, a_m_size, a_gnt} !== 6'b0_1_11_00) begin
            errors++; $display("FAIL reset_ctl: got %b want 011100", {a_m_en, a_m_rw, a_m_size, a_gnt});
        end
        checks++;
        if ({a_m_abus, a_m_dout, a_rdata} !== 96'h0) begin
            errors++; $display("FAIL reset_bus: got %h want 0", {a_m_abus, a_m_dout, a_rdata});
        end
        checks++;
        if ({a_r0_ack, a_r0_err, a_r1_ack, a_r1_err, b_m_en, b_gnt} !== 7'b0) begin
            errors++; $display("FAIL reset_ack: got %b want 0", {a_r0_ack, a_r0_err, a_r1_ack, a_r1_err, b_m_en, b_gnt});
        end
    endtask

    task automatic test_read();
        drive(0, 0, 1, 1, 2'b11, 32'h10, 32'h0);
        tick();
        checks++;
        if ({a_m_en, a_m_abus, a_gnt, a_r0_ack} !== {1'b1, 32'h10, 2'b01, 1'b0}) begin
            errors++; $display("FAIL read_grant: got en=%b abus=%h gnt=%b ack=%b want 1 10 01 0", a_m_en, a_m_abus, a_gnt, a_r0_ack);
        end
        tick();
        checks++;
        if ({a_r0_ack, a_r0_err, a_m_en, a_rdata} !== {3'b100, 32'h01020304}) begin
            errors++; $display("FAIL read_ack: got ack=%b err=%b en=%b rdata=%h want 1 0 0 01020304", a_r0_ack, a_r0_err, a_m_en, a_rdata);
        end
        drive(0, 0, 0, 1, 2'b11, 0, 0);
        tick();
        checks++;
        if ({a_r0_ack, a_gnt} !== 3'b000) begin
            errors++; $display("FAIL read_done: got ack=%b gnt=%b want 0 00", a_r0_ack, a_gnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_gnt;
        logic       exp_a0, exp_a1;
        a_reset = 1'b1; tick(); a_reset = 1'b0;
        drive(0, 0, 1, 1, 2'b11, 32'h0, 32'h0);
        drive(0, 1, 1, 0, 2'b11, 32'h20, 32'hAABBCCDD);
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_gnt = 2'b00;
            if ((k - 1) % 3 < 2) exp_gnt = (((k - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10;
            exp_a0 = (k == 2) || (k == 8);
            exp_a1 = (k == 5) || (k == 11);
            checks++;
            if ({a_gnt, a_r0_ack, a_r1_ack} !== {exp_gnt, exp_a0, exp_a1}) begin
                errors++; $display("FAIL b2b_cycle%0d: got gnt=%b a0=%b a1=%b want %b %b %b",
                                   k, a_gnt, a_r0_ack, a_r1_ack, exp_gnt, exp_a0, exp_a1);
            end
            if (exp_a0 || exp_a1) begin
                checks++;
                if (a_rdata !== 32'hDEADBEEF) begin
                    errors++; $display("FAIL b2b_rdata%0d: got %h want deadbeef", k, a_rdata);
                end
            end
        end
        drive(0, 0, 0, 1, 2'b11, 0, 0); drive(0, 1, 0, 1, 2'b11, 0, 0);
        tick();
        checks++;
        if ({mem[32], mem[33], mem[34], mem[35]} !== 32'hAABBCCDD) begin
            errors++; $display("FAIL b2b_mem: got %h want aabbccdd", {mem[32], mem[33], mem[34], mem[35]});
        end
    endtask

    task automatic test_widths();
        bit seen; logic err; logic [31:0] rd, ab; int lat, en; logic [1:0] g;
        issue(0, 1, 1, 2'b00, 32'h21, 32'h0, seen, err, rd, lat, en, ab, g);
        checks++;
        if (!seen || err !== 1'b0 || rd !== 32'h000000BB || lat != 2 || g !== 2'b10) begin
            errors++; $display("FAIL byte_read: got seen=%0d err=%b rd=%h lat=%0d gnt=%b want 1 0 000000bb 2 10", seen, err, rd, lat, g);
        end
        issue(0, 0, 1, 2'b10, 32'h20, 32'h0, seen, err, rd, lat, en, ab, g);
        checks++;
        if (!seen || rd !== 32'h00AABBCC) begin
            errors++; $display("FAIL int24_read: got seen=%0d rd=%h want 1 00aabbcc", seen, rd);
        end
        issue(0, 0, 0, 2'b01, 32'h40, 32'h1234, seen, err, rd, lat, en, ab, g);
        checks++;
        if (!seen || err !== 1'b0 || {mem[64], mem[65], mem[66]} !== 24'h123400 || rd !== 32'h00AABBCC) begin
            errors++; $display("FAIL int16_write: got seen=%0d err=%b mem=%h rd=%h want 1 0 123400 00aabbcc",
                               seen, err, {mem[64], mem[65], mem[66]}, rd);
        end
    endtask

    task automatic test_range();
        bit seen; logic err; logic [31:0] rd, ab; int lat, en; logic [1:0] g;
        issue(0, 0, 1, 2'b11, 32'h7FFFE, 32'h0, seen, err, rd, lat, en, ab, g);
        checks++;
        if (!seen || err !== 1'b1 || rd !== 32'h0 || en != 0 || lat != 1 || g !== 2'b01) begin
            errors++; $display("FAIL range_read: got seen=%0d err=%b rd=%h en=%0d lat=%0d gnt=%b want 1 1 0 0 1 01", seen, err, rd, en, lat, g);
        end
        issue(0, 0, 1, 2'b11, 32'h7FFFC, 32'h0, seen, err, rd, lat, en, ab, g);
        checks++;
        if (!seen || err !== 1'b0 || en != 1 || ab !== 32'h7FFFC) begin
            errors++; $display("FAIL edge_read: got seen=%0d err=%b en=%0d abus=%h want 1 0 1 7fffc", seen, err, en, ab);
        end
        issue(0, 0, 0, 2'b11, 32'h80000, 32'h41, seen, err, rd, lat, en, ab, g);
        checks++;
        if (!seen || err !== 1'b0 || en != 1 || ab !== 32'h80000) begin
            errors++; $display("FAIL io_write: got seen=%0d err=%b en=%0d abus=%h want 1 0 1 80000", seen, err, en, ab);
        end
        issue(0, 0, 0, 2'b11, 32'h80004, 32'h41, seen, err, rd, lat, en, ab, g);
        checks++;
        if (!seen || err !== 1'b1 || en != 0) begin
            errors++; $display("FAIL oob_write: got seen=%0d err=%b en=%0d want 1 1 0", seen, err, en);
        end
        issue(0, 1, 1, 2'b11, 32'h80000, 32'h0, seen, err, rd, lat, en, ab, g);
        checks++;
        if (!seen || err !== 1'b1 || en != 0 || g !== 2'b10) begin
            errors++; $display("FAIL io_read_r1: got seen=%0d err=%b en=%0d gnt=%b want 1 1 0 10", seen, err, en, g);
        end
    endtask

    task automatic test_wait3();
        bit seen; logic err; logic [31:0] rd, ab; int lat, en; logic [1:0] g;
        issue(1, 0, 1, 2'b11, 32'h10, 32'h0, seen, err, rd, lat, en, ab, g);
        checks++;
        if (!seen || err !== 1'b0 || en != 3 || lat != 4 || rd !== 32'hCAFEF00D) begin
            errors++; $display("FAIL wait3_read: got seen=%0d err=%b en=%0d lat=%0d rd=%h want 1 0 3 4 cafef00d", seen, err, en, lat, rd);
        end
    endtask

    task automatic test_reset_mid();
        bit seen; logic err; logic [31:0] rd, ab; int lat, en; logic [1:0] g;
        int stray;
        drive(1, 0, 1, 1, 2'b11, 32'h10, 32'h0);
        tick();
        tick();
        checks++;
        if ({b_m_en, b_gnt} !== 3'b101) begin
            errors++; $display("FAIL mid_access: got en=%b gnt=%b want 1 01", b_m_en, b_gnt);
        end
        b_reset = 1'b1;
        tick();
        drive(1, 0, 0, 1, 2'b11, 0, 0);
        b_reset = 1'b0;
        checks++;
        if ({b_m_en, b_gnt, b_r0_ack} !== 4'b0) begin
            errors++; $display("FAIL mid_reset: got en=%b gnt=%b ack=%b want 0 00 0", b_m_en, b_gnt, b_r0_ack);
        end
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (b_r0_ack || b_r1_ack || b_m_en) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL mid_dropped: got %0d active cycles want 0", stray);
        end
        issue(1, 1, 1, 2'b11, 32'h8, 32'h0, seen, err, rd, lat, en, ab, g);
        checks++;
        if (!seen || err !== 1'b0 || lat != 4 || g !== 2'b10 || en != 3) begin
            errors++; $display("FAIL after_reset_r1: got seen=%0d err=%b lat=%0d gnt=%b en=%0d want 1 0 4 10 3", seen, err, lat, g, en);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_back_to_back();
        test_widths();
        test_range();
        test_wait3();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
